// File: rtl/conv_stream_feeder_pkg.sv
// Shared constants and types for the conv_12_5 stream feeder.
package conv_pkg;

  localparam int CONV_N  = 12;
  localparam int CONV_M  = 5;
  localparam int CONV_TW = 10;
  localparam int CONV_YW = 23;

  typedef logic signed [CONV_TW-1:0] sample_t;
  typedef logic signed [CONV_YW-1:0] result_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/conv_stream_feeder_vec_stream_tx.sv
// Length-L sample buffer with a read pointer and a valid/ready transmitter.
// Beats are presented from registers; a new beat is loaded on the same edge
// that completes a handshake, so the stream runs without bubbles.
module vec_stream_tx #(
  parameter int L  = 12,
  parameter int TW = 10,
  parameter int AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [TW-1:0] wr_data_i,
  input  logic          clear_i,
  input  logic          run_i,
  input  logic          go_i,
  input  logic          ready_i,
  output logic [TW-1:0] data_o,
  output logic          valid_o
);

  localparam int PW = $clog2(L+1);
  localparam logic [PW-1:0] LEN   = PW'(L);
  localparam logic [AW:0]   LEN_A = (AW+1)'(L);

  logic [TW-1:0] mem_q [L];
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] nxt;
  logic [TW-1:0] data_q;
  logic          valid_q;

  assign nxt     = ptr_q + PW'(1);
  assign data_o  = data_q;
  assign valid_o = valid_q;

  // Buffer write; out-of-range indices are dropped and contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_i && ({1'b0, wr_addr_i} < LEN_A))
      mem_q[wr_addr_i] <= wr_data_i;
  end

  // Pointer and beat register; a raised valid only falls on handshake or leaving RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i) begin
      ptr_q   <= '0;
      valid_q <= go_i;
      data_q  <= mem_q[0];
    end else if (!run_i) begin
      valid_q <= 1'b0;
    end else if (valid_q && ready_i) begin
      ptr_q <= nxt;
      if ((nxt < LEN) && go_i) begin
        valid_q <= 1'b1;
        data_q  <= mem_q[nxt[AW-1:0]];
      end else begin
        valid_q <= 1'b0;
      end
    end else if (!valid_q && (ptr_q < LEN) && go_i) begin
      valid_q <= 1'b1;
      data_q  <= mem_q[ptr_q[AW-1:0]];
    end
  end

endmodule

// File: rtl/conv_stream_feeder.sv
// Stream driver/collector for the conv_12_5 engine: streams the loaded x and f
// vectors out, accumulates the N-M+1 y results, then parks in DONE.
// Optional macro CONV_FEEDER_THROTTLE_EN adds LFSR-driven backpressure.
module conv_stream_feeder
  import conv_pkg::*;
#(
  parameter int N  = CONV_N,
  parameter int M  = CONV_M,
  parameter int TW = CONV_TW,
  parameter int YW = CONV_YW,
  parameter int SW = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_en,
  input  logic                    ld_sel,
  input  logic [$clog2(N)-1:0]    ld_addr,
  input  logic [TW-1:0]           ld_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [TW-1:0]           x_data,
  output logic                    x_valid,
  input  logic                    x_ready,
  output logic [TW-1:0]           f_data,
  output logic                    f_valid,
  input  logic                    f_ready,
  input  logic [YW-1:0]           y_data,
  input  logic                    y_valid,
  output logic                    y_ready,
  output logic [SW-1:0]           y_sum,
  output logic [$clog2(N-M+2)-1:0] y_count
);

  localparam int K   = N - M + 1;
  localparam int CW  = $clog2(N-M+2);
  localparam int FAW = $clog2(M);
  localparam logic [CW-1:0] KC = CW'(K);

  feeder_state_t state_q, state_d;
  logic [SW-1:0] y_sum_q, sum_d;
  logic [CW-1:0] y_count_q, cnt_d;
  logic          busy_q, done_q, y_ready_q;
  logic          start_ok, ld_ok, y_hs;
  logic          go_x, go_f, y_gate_d;
  logic [SW-1:0] y_ext;

`ifdef CONV_FEEDER_THROTTLE_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Free-running backpressure source (taps 16,14,13,11).
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign go_x     = lfsr_q[0];
  assign go_f     = lfsr_q[1];
  assign y_gate_d = lfsr_d[2];
`else
  assign go_x     = 1'b1;
  assign go_f     = 1'b1;
  assign y_gate_d = 1'b1;
`endif

  assign y_ext   = {{(SW-YW){y_data[YW-1]}}, y_data};
  assign y_hs    = y_valid && y_ready;
  assign ld_ok   = ld_en && (state_q != RUN);
  assign busy    = busy_q;
  assign done    = done_q;
  assign y_ready = y_ready_q;
  assign y_sum   = y_sum_q;
  assign y_count = y_count_q;

  // Next-state: start from IDLE/DONE clears the pass; last y handshake ends it.
  always_comb begin
    state_d  = state_q;
    sum_d    = y_sum_q;
    cnt_d    = y_count_q;
    start_ok = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          sum_d    = '0;
          cnt_d    = '0;
          start_ok = 1'b1;
        end
      end
      RUN: begin
        if (y_hs) begin
          sum_d = y_sum_q + y_ext;
          cnt_d = y_count_q + CW'(1);
          if (cnt_d == KC) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered status / ready outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      y_sum_q   <= '0;
      y_count_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      y_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_sum_q   <= sum_d;
      y_count_q <= cnt_d;
      busy_q    <= (state_d == RUN);
      done_q    <= (state_d == DONE);
      y_ready_q <= (state_d == RUN) && (cnt_d < KC) && y_gate_d;
    end
  end

  vec_stream_tx #(.L(N), .TW(TW)) u_x_tx (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (ld_ok && !ld_sel),
    .wr_addr_i (ld_addr),
    .wr_data_i (ld_data),
    .clear_i   (start_ok),
    .run_i     (state_q == RUN),
    .go_i      (go_x),
    .ready_i   (x_ready),
    .data_o    (x_data),
    .valid_o   (x_valid)
  );

  vec_stream_tx #(.L(M), .TW(TW)) u_f_tx (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (ld_ok && ld_sel),
    .wr_addr_i (ld_addr[FAW-1:0]),
    .wr_data_i (ld_data),
    .clear_i   (start_ok),
    .run_i     (state_q == RUN),
    .go_i      (go_f),
    .ready_i   (f_ready),
    .data_o    (f_data),
    .valid_o   (f_valid)
  );

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed bench: the bench plays the conv_12_5 engine, computing each y from
// the beats it actually received, and checks sums against hand values.
module tb_conv_stream_feeder;

  localparam int N  = 12;
  localparam int M  = 5;
  localparam int K  = N - M + 1;
  localparam int TW = 10;
  localparam int YW = 23;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          reset, ld_en, ld_sel, start;
  logic [3:0]    ld_addr;
  logic [TW-1:0] ld_data;
  logic          busy, done;
  logic [TW-1:0] x_data, f_data;
  logic          x_valid, x_ready, f_valid, f_ready;
  logic [YW-1:0] y_data;
  logic          y_valid, y_ready;
  logic [SW-1:0] y_sum;
  logic [3:0]    y_count;

  always #5 clk = ~clk;

  conv_stream_feeder dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .busy(busy), .done(done),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .y_sum(y_sum), .y_count(y_count)
  );

  typedef struct {
    string       nm;
    int          x[N];
    int          f[M];
    logic [63:0] sum;
    int          y0;
    int          yl;
  } vec_t;

  vec_t tv[3];
  int   tests = 0;
  int   fails = 0;
  int   xm[N];
  int   fm[M];
  int   xq[$];
  int   fq[$];
  int   yq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input bit sel, input int addr, input int val);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = 4'(addr);
    ld_data = 10'(val);
  endtask

  task automatic load_vec(input int t);
    for (int i = 0; i < N; i++) begin wr(1'b0, i, tv[t].x[i]); xm[i] = tv[t].x[i]; end
    for (int i = 0; i < M; i++) begin wr(1'b1, i, tv[t].f[i]); fm[i] = tv[t].f[i]; end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One full pass with the bench acting as the engine.
  task automatic run_pass(input string nm, input logic [63:0] exp_sum, input int y0,
                          input int yl, input int stall_at, input bit poke);
    int stall_n, yi, bad, yv;
    logic [TW-1:0] held;
    stall_n = 0; yi = 0; bad = 0; yv = 0; held = '0;
    xq.delete(); fq.delete(); yq.delete();
    @(negedge clk);
    start = 1'b1; x_ready = 1'b1; f_ready = 1'b1; y_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " first x_valid"}, 64'(x_valid), 64'd1);
    chk({nm, " first f_valid"}, 64'(f_valid), 64'd1);
    chk({nm, " busy"}, 64'(busy), 64'd1);
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      x_ready = 1'b1;
      if (stall_at >= 0 && xq.size() == stall_at && stall_n < 3) begin
        x_ready = 1'b0;
        chk({nm, " stall x_valid"}, 64'(x_valid), 64'd1);
        if (stall_n == 0) begin
          held = x_data;
          chk({nm, " stall x_data"}, 64'($signed(x_data)), 64'(xm[stall_at]));
        end else begin
          chk({nm, " stall x_data stable"}, 64'(x_data), 64'(held));
        end
        stall_n++;
      end
      start   = poke && (cyc == 3);
      ld_en   = poke && (cyc == 3);
      ld_sel  = 1'b0;
      ld_addr = 4'd0;
      ld_data = 10'd99;
      y_valid = 1'b0;
      if (yi < K && xq.size() >= yi + M && fq.size() == M) begin
        yv = 0;
        for (int k = 0; k < M; k++) yv += xq[yi+k] * fq[k];
        y_valid = 1'b1;
        y_data  = YW'(yv);
      end
      #1;
      if (x_valid && x_ready) xq.push_back(int'($signed(x_data)));
      if (f_valid && f_ready) fq.push_back(int'($signed(f_data)));
      if (y_valid && y_ready) begin yq.push_back(yv); yi++; end
      @(negedge clk);
    end
    start = 1'b0; ld_en = 1'b0; y_valid = 1'b0;
    chk({nm, " done"}, 64'(done), 64'd1);
    chk({nm, " busy end"}, 64'(busy), 64'd0);
    chk({nm, " y_ready end"}, 64'(y_ready), 64'd0);
    chk({nm, " x_valid end"}, 64'(x_valid), 64'd0);
    chk({nm, " y_count"}, 64'(y_count), 64'(K));
    chk({nm, " y_sum"}, 64'(y_sum), exp_sum);
    chk({nm, " y beats"}, 64'(yq.size()), 64'(K));
    chk({nm, " first y"}, 64'(yq.size() > 0 ? yq[0] : -1), 64'(y0));
    chk({nm, " last y"}, 64'(yq.size() == K ? yq[K-1] : -1), 64'(yl));
    for (int i = 0; i < N; i++) if (i >= xq.size() || xq[i] != xm[i]) bad++;
    if (xq.size() != N) bad++;
    chk({nm, " x stream"}, 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < M; i++) if (i >= fq.size() || fq[i] != fm[i]) bad++;
    if (fq.size() != M) bad++;
    chk({nm, " f stream"}, 64'(bad), 64'd0);
  endtask

  initial begin
    reset = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; x_ready = 1'b0; f_ready = 1'b0; y_valid = 1'b0; y_data = '0;

    tv[0].nm = "pickoff"; tv[0].sum = 64'd52;       tv[0].y0 = 3;       tv[0].yl = 10;
    tv[1].nm = "movsum";  tv[1].sum = 64'd260;      tv[1].y0 = 15;      tv[1].yl = 50;
    tv[2].nm = "worst";   tv[2].sum = 64'd10485760; tv[2].y0 = 1310720; tv[2].yl = 1310720;
    for (int i = 0; i < N; i++) begin
      tv[0].x[i] = i + 1; tv[1].x[i] = i + 1; tv[2].x[i] = -512;
    end
    for (int i = 0; i < M; i++) begin
      tv[0].f[i] = (i == 2) ? 1 : 0; tv[1].f[i] = 1; tv[2].f[i] = -512;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst x_valid", 64'(x_valid), 64'd0);
    chk("rst f_valid", 64'(f_valid), 64'd0);
    chk("rst y_ready", 64'(y_ready), 64'd0);
    chk("rst y_sum", 64'(y_sum), 64'd0);
    chk("rst y_count", 64'(y_count), 64'd0);
    reset = 1'b0;

    // Table-driven passes (later loads happen while in DONE)
    for (int t = 0; t < 3; t++) begin
      load_vec(t);
      run_pass(tv[t].nm, tv[t].sum, tv[t].y0, tv[t].yl, -1, 1'b0);
    end

    // Backpressure on x mid-vector
    load_vec(0);
    run_pass("stall", 64'd52, 3, 10, 4, 1'b0);

    // start and ld_en while busy are ignored; start from DONE repeats the pass
    run_pass("poke", 64'd52, 3, 10, -1, 1'b1);
    run_pass("rerun", 64'd52, 3, 10, -1, 1'b0);

    // y_valid in DONE is not accepted; results hold
    @(negedge clk); y_valid = 1'b1; y_data = 23'd1000;
    repeat (2) @(negedge clk);
    y_valid = 1'b0;
    chk("done hold y_count", 64'(y_count), 64'(K));
    chk("done hold y_sum", 64'(y_sum), 64'd52);
    chk("done hold done", 64'(done), 64'd1);

    // Out-of-range writes are dropped
    wr(1'b0, 12, 77);
    wr(1'b1, 5, 77);
    @(negedge clk); ld_en = 1'b0;
    run_pass("oob", 64'd52, 3, 10, -1, 1'b0);

    // Reset after 4 x beats, then a clean pass from the kept buffers
    @(negedge clk); start = 1'b1; x_ready = 1'b1; f_ready = 1'b0; y_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst x_data beat4", 64'($signed(x_data)), 64'(xm[4]));
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst x_valid", 64'(x_valid), 64'd0);
    chk("midrst f_valid", 64'(f_valid), 64'd0);
    chk("midrst y_ready", 64'(y_ready), 64'd0);
    chk("midrst y_count", 64'(y_count), 64'd0);
    run_pass("after rst", 64'd52, 3, 10, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_stream_feeder.md
Name: conv_stream_feeder

Overview:
- On-chip stream driver and collector for the conv_12_5 convolution engine.
- A host loads one N-element x vector and one M-element f vector into local buffers, then pulses start.
- The block transmits both vectors over independent valid/ready streams to the engine.
- It accepts the N-M+1 y results, keeping a running signed sum and count of them. It raises done after the last result.

Parameters:
- N, 12: x vector length.
- M, 5: f vector length.
- TW, 10: signed x/f sample width.
- YW, 23: signed y result width.
- SW, 32: signed running-sum width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- ld_en  in  1  write strobe into the local buffers.
- ld_sel  in  1  buffer select: 0 = x buffer, 1 = f buffer.
- ld_addr  in  $clog2(N)  write index; f writes use the low $clog2(M) bits.
- ld_data  in  TW  signed sample to write.
- start  in  1  begin one transfer pass.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- x_data  out  TW  x stream data.
- x_valid  out  1  x stream valid.
- x_ready  in  1  x stream ready from the engine.
- f_data  out  TW  f stream data.
- f_valid  out  1  f stream valid.
- f_ready  in  1  f stream ready from the engine.
- y_data  in  YW  signed result from the engine.
- y_valid  in  1  result valid.
- y_ready  out  1  result ready.
- y_sum  out  SW  sign-extended running sum of accepted y_data.
- y_count  out  $clog2(N-M+2)  number of y results accepted.

Behaviour:
- Reset values: state IDLE; x_valid, f_valid, y_ready, busy, done = 0; y_sum = 0; y_count = 0; x/f read pointers = 0.
- Buffer contents are not cleared by reset.
- FSM IDLE:
  - ld_en writes ld_data into buffer[ld_sel][ld_addr] at the clock edge.
  - Out-of-range addresses (x >= N, f >= M) are dropped.
  - start moves to RUN and clears y_sum, y_count and both pointers.
- FSM RUN:
  - busy = 1.
  - ld_en and start are ignored.
  - Moves to DONE the cycle after the y handshake that makes y_count = N-M+1.
- FSM DONE:
  - done = 1; y_sum and y_count hold.
  - start re-enters RUN with the same clearing as from IDLE.
  - ld_en is accepted, so buffers can be reloaded before the next start.
- x stream:
  - In RUN, x_valid = 1 while x_ptr < N, with x_data = xbuf[x_ptr], driven from registers.
  - On x_valid && x_ready, x_ptr increments at that edge.
  - Once asserted, x_valid and x_data stay stable until the handshake.
  - Zero-bubble: a new beat is presented the cycle after a handshake if data remains.
- f stream: identical rules with f_ptr, M and fbuf. It is fully independent of x; there is no ordering between the two streams.
- y stream:
  - y_ready = 1 in RUN while y_count < N-M+1.
  - On y_valid && y_ready: y_sum += sext(y_data) and y_count += 1 at that edge.
  - y_valid arriving in IDLE or DONE is not accepted, because y_ready = 0.
- Simultaneous x, f and y handshakes in one cycle are all honoured.
- Reset mid-RUN: returns to IDLE at that edge and drops all valids and ready next cycle. No partial-beat completion.
- Latency: first x_valid and f_valid are high in the cycle after the edge that samples start.
- Overflow: y_sum wraps modulo 2^SW. There is no saturation.

Optional Feature:
- Macro CONV_FEEDER_THROTTLE_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (seed 16'hACE1 on reset, taps 16,14,13,11) advances every cycle.
  - LFSR bits [0], [1] and [2] gate, respectively, starting a new x beat, starting a new f beat and asserting y_ready.
  - A valid already high is never dropped by throttling, so the stability rule still holds.
  - Used for self-contained backpressure stress.
- When undefined: no LFSR; the streams run at full rate as above.

Decomposition:
- Package conv_pkg:
  - constants CONV_N=12, CONV_M=5, CONV_TW=10, CONV_YW=23;
  - typedef logic signed [CONV_TW-1:0] sample_t;
  - typedef logic signed [CONV_YW-1:0] result_t;
  - enum feeder_state_t {IDLE, RUN, DONE}.
- One natural sub-module, vec_stream_tx: a parameterised length-L buffer plus pointer and valid/ready transmitter. It is instantiated twice, once for x and once for f.

Test Plan:
- Directed, with the DUT connected to a conv_12_5 instance.
- Filter pick-off: x = 1..12, f = 0,0,1,0,0, start -> y results 3..10 in order; done = 1, y_count = 8, y_sum = 52.
- Moving sum: x = 1..12, f = 1,1,1,1,1 -> y = 15,20,...,50; y_sum = 260.
- Worst-case width: all x = -512, all f = -512 -> every y = 1310720; y_sum = 10485760, no wrap.
- Backpressure: hold x_ready = 0 for 3 cycles mid-vector -> x_valid stays 1 and x_data stays constant; no element is skipped or duplicated.
- Reset mid-RUN after 4 x beats -> next cycle busy = 0, all valids = 0, y_count = 0. Buffers are kept, so start reproduces y_sum = 52 for the pick-off data.
- Control and load rules:
  - start and ld_en asserted while busy -> no effect.
  - start in DONE -> a second identical pass giving the same y_sum.
  - ld_addr = 12 (x) or 5 (f) -> write ignored.
